// File: rtl/sort_job_ctrl.sv
`timescale 1ns/1ps
// sort_job_ctrl
// Job sequencer for the rank-value selection sorter in the PageRank sort path.
// It collects one job of up to NUM_WORDS rank words into a flat buffer and
// holds the sorter in restart while the buffer fills. It then releases the
// sorter and waits for its done flag. Finally it streams the real words of
// the job downstream, largest first.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  upstream handshake; in_data word, in_last ends the job
//   sort_array_in      flat buffer to the sorter, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   sort_restart       sorter reset (active-high), low only while sorting/draining
//   sort_done          sorter done flag
//   sort_array_out     sorted flat array from the sorter, ascending
//   out_valid/out_ready downstream handshake; out_data word, out_last ends the job
//   busy               controller is not idle
//   sort_cycles        cycles spent waiting on the sorter for the last job, saturating
//
// state   | meaning
// S_IDLE  | waiting for the first word of a job
// S_LOAD  | accepting further words into the buffer
// S_KICK  | one cycle of restart so the sorter samples the stable buffer
// S_WAIT  | sorter running, counting cycles until done
// S_DRAIN | emitting the real words from the top index downward
module sort_job_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WORDS  = 32,
   parameter int CNT_W      = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [DATA_WIDTH-1:0]           in_data,
   input  logic                            in_last,
   output logic [DATA_WIDTH*NUM_WORDS-1:0] sort_array_in,
   output logic                            sort_restart,
   input  logic                            sort_done,
   input  logic [DATA_WIDTH*NUM_WORDS-1:0] sort_array_out,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [DATA_WIDTH-1:0]           out_data,
   output logic                            out_last,
   output logic                            busy,
   output logic [CNT_W-1:0]                sort_cycles
);

   localparam int CW = $clog2(NUM_WORDS + 1);
   localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [CW-1:0] NW_C    = CW'(NUM_WORDS);
   localparam logic [IW-1:0] TOP_IDX = IW'(NUM_WORDS - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KICK, S_WAIT, S_DRAIN} state_t;

   state_t                            state_q, state_d;
   logic [DATA_WIDTH*NUM_WORDS-1:0]   buf_q, buf_d;
   logic [CW-1:0]                     count_q, count_d;
   logic [IW-1:0]                     idx_q, idx_d;
   logic                              out_valid_q, out_valid_d;
   logic                              out_last_q, out_last_d;
   logic [DATA_WIDTH-1:0]             out_data_q, out_data_d;
   logic [CNT_W-1:0]                  cyc_q, cyc_d;
   logic [CW-1:0]                     last_idx;
   logic [IW-1:0]                     idx_nx;
   logic                              fire;

   // Unused upper slots hold zero and sort to the bottom, so the smallest
   // real word of the job sits at NUM_WORDS-count.
   assign last_idx = NW_C - count_q;
   assign idx_nx   = idx_q - 1'b1;
   assign fire     = out_valid_q && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         buf_q       <= '0;
         count_q     <= '0;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         cyc_q       <= '0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         count_q     <= count_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         cyc_q       <= cyc_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      count_d     = count_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      cyc_d       = cyc_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               // Clearing the whole buffer here removes any residue of the
               // previous job from the slots this job leaves unused.
               buf_d                   = '0;
               buf_d[DATA_WIDTH-1:0]   = in_data;
               count_d                 = CW'(1);
               state_d                 = (in_last || NUM_WORDS == 1) ? S_KICK : S_LOAD;
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               for (int i = 0; i < NUM_WORDS; i++) begin
                  if (count_q == CW'(i)) buf_d[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
               end
               count_d = count_q + 1'b1;
               // A full buffer ends the job whether or not in_last is set.
               if (in_last || count_d == NW_C) state_d = S_KICK;
            end
         end
         S_KICK: begin
            cyc_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
            if (sort_done) begin
               state_d     = S_DRAIN;
               idx_d       = TOP_IDX;
               out_valid_d = 1'b1;
               out_data_d  = sort_array_out[(NUM_WORDS-1)*DATA_WIDTH +: DATA_WIDTH];
               out_last_d  = (CW'(TOP_IDX) == last_idx);
            end
         end
         S_DRAIN: begin
            if (fire) begin
               if (out_last_q) begin
                  state_d     = S_IDLE;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  out_data_d  = '0;
               end else begin
                  idx_d      = idx_nx;
                  out_data_d = sort_array_out[idx_nx*DATA_WIDTH +: DATA_WIDTH];
                  out_last_d = (CW'(idx_nx) == last_idx);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready      = (state_q == S_IDLE) || (state_q == S_LOAD);
   assign sort_restart  = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_KICK);
   assign busy          = (state_q != S_IDLE);
   assign sort_array_in = buf_q;
   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;
   assign out_last      = out_last_q;
   assign sort_cycles   = cyc_q;

endmodule

// File: tb/tb_sort_job_ctrl.sv
`timescale 1ns/1ps
module tb_sort_job_ctrl;

   localparam int DW = 32;
   localparam int NW = 8;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid, in_last, out_ready, sort_done;
   logic [DW-1:0]       in_data;
   logic [DW*NW-1:0]    sort_array_out;

   logic                in_ready, sort_restart, out_valid, out_last, busy;
   logic [DW*NW-1:0]    sort_array_in;
   logic [DW-1:0]       out_data;
   logic [15:0]         sort_cycles;

   logic                in_ready4, sort_restart4, out_valid4, out_last4, busy4;
   logic [DW*NW-1:0]    sort_array_in4;
   logic [DW-1:0]       out_data4;
   logic [3:0]          sort_cycles4;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   sort_job_ctrl #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .sort_array_in(sort_array_in), .sort_restart(sort_restart),
      .sort_done(sort_done), .sort_array_out(sort_array_out), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy),
      .sort_cycles(sort_cycles));

   // Same stimulus, narrow duration counter to exercise saturation.
   sort_job_ctrl #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
      .in_last(in_last), .sort_array_in(sort_array_in4), .sort_restart(sort_restart4),
      .sort_done(sort_done), .sort_array_out(sort_array_out), .out_valid(out_valid4),
      .out_ready(out_ready), .out_data(out_data4), .out_last(out_last4), .busy(busy4),
      .sort_cycles(sort_cycles4));

   // Sorter stand-in: ascending sort of its input, done after done_delay
   // cycles out of restart.
   int unsigned done_delay = 5;
   int unsigned srt_cnt;
   always_ff @(posedge clk) begin
      if (sort_restart) srt_cnt <= 0;
      else              srt_cnt <= srt_cnt + 1;
   end
   assign sort_done = !sort_restart && (srt_cnt + 1 >= done_delay);

   function automatic logic [DW*NW-1:0] sort_flat(input logic [DW*NW-1:0] a);
      logic [DW-1:0] w [NW];
      logic [DW-1:0] t;
      logic [DW*NW-1:0] r;
      for (int i = 0; i < NW; i++) w[i] = a[i*DW +: DW];
      for (int i = 0; i < NW; i++)
         for (int j = 0; j < NW-1-i; j++)
            if (w[j] > w[j+1]) begin t = w[j]; w[j] = w[j+1]; w[j+1] = t; end
      for (int i = 0; i < NW; i++) r[i*DW +: DW] = w[i];
      return r;
   endfunction
   assign sort_array_out = sort_flat(sort_array_in);

   // Reference: a job yields its own words largest first, last flag on the final one.
   int unsigned job_q[$];
   int unsigned exp_q[$];
   int unsigned got_q[$];
   bit          last_q[$];
   int unsigned cyc16_r, cyc4_r;
   logic [DW*NW-1:0] arr_r, exp_buf;
   int          stall_bad, ctrl_bad, load_bad;
   bit          to_flag;
   bit          pat [4];

   function automatic void build_expect();
      exp_q = job_q;
      exp_q.rsort();
      exp_buf = '0;
      foreach (job_q[i]) if (i < NW) exp_buf[i*DW +: DW] = job_q[i];
   endfunction

   function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic drive_job(input bit use_last);
      int g;
      load_bad = 0;
      to_flag  = 0;
      foreach (job_q[i]) begin
         in_valid = 1'b1;
         in_data  = job_q[i];
         in_last  = use_last && (i == job_q.size() - 1);
         g = 0;
         while (in_ready !== 1'b1 && g < 1000) begin @(negedge clk); g++; end
         if (g >= 1000) to_flag = 1;
         if (sort_restart !== 1'b1 || out_valid !== 1'b0) load_bad++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
   task automatic collect(input int mode);
      int k;
      bit seen, held, fin;
      logic [DW-1:0] hd;
      logic hl;
      k = 0; seen = 0; held = 0; fin = 0; hd = '0; hl = 1'b0;
      got_q.delete(); last_q.delete();
      stall_bad = 0; ctrl_bad = 0; cyc16_r = 0; cyc4_r = 0; arr_r = '0;
      for (int c = 0; c < 3000 && !fin; c++) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = pat[k % 4];
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (out_valid === 1'b1) begin
            if (!seen) begin
               seen = 1; cyc16_r = sort_cycles; cyc4_r = sort_cycles4; arr_r = sort_array_in;
            end
            if (held && (out_data !== hd || out_last !== hl)) stall_bad++;
            if (sort_restart !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) ctrl_bad++;
            if (out_valid4 !== 1'b1 || busy4 !== 1'b1 || sort_restart4 !== 1'b0 || in_ready4 !== 1'b0 ||
                out_data4 !== out_data || out_last4 !== out_last || sort_array_in4 !== sort_array_in) ctrl_bad++;
            if (out_ready) begin
               got_q.push_back(out_data);
               last_q.push_back(out_last);
               held = 0;
               if (out_last === 1'b1 || got_q.size() > NW) fin = 1;
            end else begin
               held = 1; hd = out_data; hl = out_last;
            end
            k++;
         end
         @(negedge clk);
      end
      to_flag   = !fin;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      nvec++;
      if (busy !== 1'b0 || in_ready !== 1'b1 || sort_restart !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
         nerr++;
         $display("FAIL reset_ctrl: busy=%0b in_ready=%0b restart=%0b out_valid=%0b out_last=%0b, want 0 1 1 0 0",
                  busy, in_ready, sort_restart, out_valid, out_last);
      end
      nvec++;
      if (out_data !== '0 || sort_cycles !== '0 || sort_array_in !== '0 || sort_cycles4 !== '0) begin
         nerr++;
         $display("FAIL reset_data: out_data=%0h sort_cycles=%0d buf=%0h, want all zero", out_data, sort_cycles, sort_array_in);
      end
      rst = 1'b0;
      @(negedge clk);
      nvec++;
      if (busy !== 1'b0 || in_ready !== 1'b1 || sort_restart !== 1'b1) begin
         nerr++;
         $display("FAIL post_reset_idle: busy=%0b in_ready=%0b restart=%0b, want 0 1 1", busy, in_ready, sort_restart);
      end
   endtask

   task automatic test_full_job();
      job_q = '{5, 1, 7, 3, 2, 8, 6, 4};
      build_expect();
      done_delay = 4;
      drive_job(1);
      nvec++;
      if (to_flag || load_bad != 0) begin
         nerr++; $display("FAIL full_load: timeout=%0b bad_beats=%0d, want 0 0", to_flag, load_bad);
      end
      nvec++;
      if (sort_restart !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
         nerr++; $display("FAIL full_kick: restart=%0b busy=%0b in_ready=%0b, want 1 1 0", sort_restart, busy, in_ready);
      end
      @(negedge clk);
      nvec++;
      if (sort_restart !== 1'b0 || out_valid !== 1'b0) begin
         nerr++; $display("FAIL full_wait: restart=%0b out_valid=%0b, want 0 0", sort_restart, out_valid);
      end
      collect(0);
      nvec++;
      if (to_flag || got_q.size() != exp_q.size()) begin
         nerr++; $display("FAIL full_count: timeout=%0b beats=%0d, want 0 %0d", to_flag, got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         nvec++;
         if (got_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) begin
            nerr++; $display("FAIL full_word[%0d]: data=%0d last=%0b, want %0d %0b", i, got_q[i], last_q[i], exp_q[i], i == exp_q.size() - 1);
         end
      end
      nvec++;
      if (ctrl_bad != 0 || arr_r !== exp_buf || cyc16_r != 4) begin
         nerr++; $display("FAIL full_drain_ctrl: bad=%0d buf=%0h cycles=%0d, want 0 %0h 4", ctrl_bad, arr_r, cyc16_r, exp_buf);
      end
      nvec++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || sort_restart !== 1'b1) begin
         nerr++; $display("FAIL full_end: out_valid=%0b busy=%0b restart=%0b, want 0 0 1", out_valid, busy, sort_restart);
      end
   endtask

   task automatic test_short_job();
      job_q = '{9, 2, 4};
      build_expect();
      done_delay = 2;
      drive_job(1);
      collect(0);
      nvec++;
      if (to_flag || got_q.size() != 3) begin
         nerr++; $display("FAIL short_count: timeout=%0b beats=%0d, want 0 3", to_flag, got_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         nvec++;
         if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 2)) begin
            nerr++; $display("FAIL short_word[%0d]: data=%0d last=%0b, want %0d %0b", i, got_q[i], last_q[i], exp_q[i], i == 2);
         end
      end
      nvec++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || arr_r !== exp_buf) begin
         nerr++; $display("FAIL short_end: out_valid=%0b busy=%0b buf=%0h, want 0 0 %0h", out_valid, busy, arr_r, exp_buf);
      end
   endtask

   task automatic test_forced_end();
      job_q = '{10, 80, 30, 50, 20, 70, 40, 60};
      build_expect();
      done_delay = 3;
      drive_job(0);
      in_valid = 1'b1; in_data = 99; in_last = 1'b1;
      nvec++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         nerr++; $display("FAIL forced_stop: in_ready=%0b busy=%0b, want 0 1", in_ready, busy);
      end
      collect(0);
      nvec++;
      if (to_flag || got_q.size() != 8 || ctrl_bad != 0) begin
         nerr++; $display("FAIL forced_count: timeout=%0b beats=%0d bad=%0d, want 0 8 0", to_flag, got_q.size(), ctrl_bad);
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         nvec++;
         if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 7)) begin
            nerr++; $display("FAIL forced_word[%0d]: data=%0d last=%0b, want %0d %0b", i, got_q[i], last_q[i], exp_q[i], i == 7);
         end
      end
      nvec++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         nerr++; $display("FAIL forced_idle: in_ready=%0b busy=%0b, want 1 0", in_ready, busy);
      end
      job_q = '{99};
      build_expect();
      drive_job(1);
      collect(0);
      nvec++;
      if (to_flag || got_q.size() != 1) begin
         nerr++; $display("FAIL held_beat_count: timeout=%0b beats=%0d, want 0 1", to_flag, got_q.size());
      end else begin
         nvec++;
         if (got_q[0] !== 99 || last_q[0] !== 1'b1) begin
            nerr++; $display("FAIL held_beat_word: data=%0d last=%0b, want 99 1", got_q[0], last_q[0]);
         end
      end
   endtask

   task automatic test_stall();
      job_q = '{11, 44, 22, 33};
      build_expect();
      done_delay = 6;
      drive_job(1);
      collect(1);
      nvec++;
      if (to_flag || got_q.size() != 4 || stall_bad != 0) begin
         nerr++; $display("FAIL stall_count: timeout=%0b beats=%0d unstable=%0d, want 0 4 0", to_flag, got_q.size(), stall_bad);
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         nvec++;
         if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 3)) begin
            nerr++; $display("FAIL stall_word[%0d]: data=%0d last=%0b, want %0d %0b", i, got_q[i], last_q[i], exp_q[i], i == 3);
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      job_q = '{5, 6, 7};
      done_delay = 200;
      drive_job(1);
      @(negedge clk);
      @(negedge clk);
      nvec++;
      if (sort_restart !== 1'b0 || busy !== 1'b1) begin
         nerr++; $display("FAIL midrst_in_wait: restart=%0b busy=%0b, want 0 1", sort_restart, busy);
      end
      rst = 1'b1;
      #1;
      nvec++;
      if (busy !== 1'b0 || sort_restart !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
          out_last !== 1'b0 || sort_cycles !== '0 || sort_array_in !== '0) begin
         nerr++; $display("FAIL midrst_async: busy=%0b restart=%0b out_valid=%0b in_ready=%0b cycles=%0d, want 0 1 0 1 0",
                          busy, sort_restart, out_valid, in_ready, sort_cycles);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      job_q = '{3, 1};
      build_expect();
      done_delay = 3;
      drive_job(1);
      collect(0);
      nvec++;
      if (to_flag || got_q.size() != 2) begin
         nerr++; $display("FAIL midrst_count: timeout=%0b beats=%0d, want 0 2", to_flag, got_q.size());
      end else begin
         nvec++;
         if (got_q[0] !== 3 || got_q[1] !== 1 || last_q[0] !== 1'b0 || last_q[1] !== 1'b1) begin
            nerr++; $display("FAIL midrst_words: got %0d,%0d last %0b,%0b, want 3,1 last 0,1", got_q[0], got_q[1], last_q[0], last_q[1]);
         end
      end
   endtask

   task automatic test_sort_cycles();
      job_q = '{12, 7, 19, 3, 25, 8, 14, 1};
      build_expect();
      done_delay = 40;
      drive_job(1);
      collect(0);
      nvec++;
      if (to_flag || cyc16_r != 40 || cyc4_r != 15) begin
         nerr++; $display("FAIL sort_cycles: timeout=%0b cnt16=%0d cnt4=%0d, want 0 40 15", to_flag, cyc16_r, cyc4_r);
      end
      nvec++;
      if (got_q.size() != 8 || got_q[0] !== 25 || got_q[got_q.size()-1] !== 1) begin
         nerr++; $display("FAIL sort_cycles_data: beats=%0d, want 8 from 25 down to 1", got_q.size());
      end
   endtask

   task automatic test_random();
      int len;
      bit ul;
      for (int j = 0; j < 20; j++) begin
         len = $urandom_range(1, NW);
         job_q.delete();
         for (int i = 0; i < len; i++) job_q.push_back($urandom_range(0, 300));
         ul = (len < NW) ? 1'b1 : 1'($urandom_range(0, 1));
         build_expect();
         done_delay = $urandom_range(1, 30);
         drive_job(ul);
         collect(2);
         nvec++;
         if (to_flag || load_bad != 0 || got_q.size() != exp_q.size() || stall_bad != 0 || ctrl_bad != 0) begin
            nerr++; $display("FAIL rand%0d_ctrl: timeout=%0b beats=%0d unstable=%0d bad=%0d, want 0 %0d 0 0",
                             j, to_flag, got_q.size(), stall_bad, ctrl_bad, exp_q.size());
         end
         foreach (exp_q[i]) if (i < got_q.size()) begin
            nvec++;
            if (got_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) begin
               nerr++; $display("FAIL rand%0d_word[%0d]: data=%0d last=%0b, want %0d %0b",
                                j, i, got_q[i], last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
         end
         nvec++;
         if (arr_r !== exp_buf || cyc16_r != done_delay || cyc4_r != sat(done_delay, 15)) begin
            nerr++; $display("FAIL rand%0d_buf_cycles: cnt16=%0d cnt4=%0d, want %0d %0d", j, cyc16_r, cyc4_r, done_delay, sat(done_delay, 15));
         end
      end
   endtask

   initial begin
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_full_job();
      test_short_job();
      test_forced_end();
      test_stall();
      test_reset_mid_wait();
      test_sort_cycles();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/sort_job_ctrl.md
Name: sort_job_ctrl

Overview:
Job sequencer for the rank-value selection sorter in the PageRank sort path. It collects one job of up to NUM_WORDS rank words from an upstream valid/ready stream into a flat buffer, then releases and launches the sorter and waits for its done flag. It then drains the sorted result downstream in descending order, emitting only the real words of the job.

Parameters:
DATA_WIDTH, 32, width of one rank word (unsigned)
NUM_WORDS, 32, sorter capacity in words; must equal the sorter's NUM_WORDS
CNT_W, 16, width of the sort-duration counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  upstream word valid
in_ready  out  1  controller accepts a word
in_data  in  DATA_WIDTH  rank word
in_last  in  1  final word of the job
sort_array_in  out  DATA_WIDTH*NUM_WORDS  flat buffer to sorter; word i at bits [i*DATA_WIDTH +: DATA_WIDTH]
sort_restart  out  1  drives the sorter's rst (active-high)
sort_done  in  1  sorter done flag
sort_array_out  in  DATA_WIDTH*NUM_WORDS  sorted flat array from sorter (ascending, index 0 smallest)
out_valid  out  1  downstream word valid
out_ready  in  1  downstream accepts
out_data  out  DATA_WIDTH  sorted word
out_last  out  1  final word of job
busy  out  1  state != IDLE
sort_cycles  out  CNT_W  cycles spent in WAIT for the last job, saturating

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high.
- Reset values: state=IDLE, buffer all zero, count=0, in_ready=1, sort_restart=1, out_valid=0, out_last=0, out_data=0, busy=0, sort_cycles=0.
- States: IDLE, LOAD, KICK, WAIT, DRAIN.
- Unsigned width rule: count is $clog2(NUM_WORDS+1) bits.
- in_ready=1 only in IDLE and LOAD.
- sort_restart=1 in IDLE, LOAD and KICK; sort_restart=0 in WAIT and DRAIN.
- IDLE:
  - On the first accepted beat, write the word to buffer[0], set count=1, and clear the rest of the buffer to zero in the same cycle.
  - Go to KICK if in_last, otherwise go to LOAD.
- LOAD:
  - Each accepted beat writes buffer[count] and increments count.
  - Go to KICK when in_last is accepted, or when the NUM_WORDS-th word is accepted (forced end; in_last is ignored).
  - Zero words stay in the unused upper slots. Because data is unsigned, they sort to the low indices.
- KICK: one cycle with sort_restart still high, so the sorter samples the stable buffer. Clear sort_cycles. Go to WAIT.
- WAIT:
  - sort_restart=0.
  - Increment sort_cycles each cycle; saturate at all-ones.
  - When sort_done=1, go to DRAIN with idx=NUM_WORDS-1.
  - There is no timeout.
- DRAIN:
  - out_valid=1 and out_data=sort_array_out word[idx], registered.
  - out_last=1 when idx==NUM_WORDS-count.
  - On out_valid&&out_ready: decrement idx; after the last word, go to IDLE.
  - While out_valid&&!out_ready, out_data and out_last hold stable.
  - sort_array_in stays unchanged from KICK until the return to IDLE.
- Latency:
  - First output word is valid no earlier than 1 cycle after sort_done is sampled high.
  - Output throughput is one word per cycle under continuous out_ready.
- Simultaneous events: in_valid is ignored outside IDLE/LOAD (in_ready=0). A new job's first beat is accepted in the cycle after the final out handshake.
- Reset mid-operation: immediate return to IDLE with reset values and sort_restart=1. Partial output is abandoned, with no out_last.
- sort_done high while in IDLE/LOAD/KICK is ignored.

Test Plan:
- NUM_WORDS=8, job {5,1,7,3,2,8,6,4} with in_last on beat 8 -> out stream 8,7,6,5,4,3,2,1, out_last only on 1; sort_restart low only from WAIT entry to the end of DRAIN.
- Short job {9,2,4} with in_last on beat 3 -> out 9,4,2 with out_last on 2; exactly 3 output beats, and no zero padding is emitted.
- 8 beats, no in_last (9th beat presented) -> job ends at beat 8; 9th beat held with in_ready=0 until IDLE, then accepted as the first word of the next job.
- out_ready toggled 1,0,0,1 during DRAIN -> out_data/out_last stable during stalls, with no word lost or duplicated.
- rst pulsed for 1 cycle mid-WAIT -> busy=0 and sort_restart=1 immediately, out_valid=0; a following job {3,1} yields out 3,1.
- Job of 8 words with sorter model done after 40 cycles -> sort_cycles=40 at DRAIN entry; with CNT_W=4 and the same job, sort_cycles=15 (saturated).
